systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 143 ++++++++++++++
 tb/tb_systolic_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Captures one 3x3 pair of matrices (A, B) and streams them, skewed in time,
// into a 3x3 output-stationary systolic array. Row i of A enters on left[i]
// delayed by i steps. Column j of B enters on top[j] delayed by j steps.
// Because of this skew, operand k of A[i][*] meets operand k of B[*][j]
// inside PE(i,j).
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous, active-high reset
//   start    request one transfer (sampled only in IDLE)
//   a_in     A, element A[i][k] at [(3i+k)*5 +: 5]
//   b_in     B, element B[k][j] at [(3k+j)*5 +: 5]
//   left     row operand lanes, left[i] feeds array row i (registered)
//   top      column operand lanes, top[j] feeds array column j (registered)
//   arr_clr  one-cycle accumulator clear to the array (registered)
//   busy     high in CLEAR, FEED and DRAIN (registered)
//   done     one-cycle pulse, array results valid (registered)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands captured on the accepting edge
// CLEAR   | arr_clr high for one cycle
// FEED    | step counter t = 0..6 drives skewed operands onto left/top
// DRAIN   | 3 cycles for the last products to ripple through the array
// DONE    | done high for one cycle, then back to IDLE
module systolic_feeder (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [44:0]      a_in,
    input  logic [44:0]      b_in,
    output logic [2:0][4:0]  left,
    output logic [2:0][4:0]  top,
    output logic             arr_clr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      t;
    logic [1:0]      drain_cnt;
    logic [44:0]     a_q;
    logic [44:0]     b_q;

    logic [2:0]      t_nxt;
    logic [2:0][4:0] left_nxt;
    logic [2:0][4:0] top_nxt;

    // Lane values are computed for the step the outputs will show after the
    // next edge. This keeps left/top registered and still aligned with t.
    always_comb begin
        t_nxt    = (state == S_FEED) ? t + 3'd1 : 3'd0;
        left_nxt = '0;
        top_nxt  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (int'(t_nxt) == i + k) begin
                    left_nxt[i] = a_q[(3*i+k)*5 +: 5];
                    top_nxt[i]  = b_q[(3*k+i)*5 +: 5];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            t         <= 3'd0;
            drain_cnt <= 2'd0;
            a_q       <= '0;
            b_q       <= '0;
            left      <= '0;
            top       <= '0;
            arr_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CLEAR;
                        a_q     <= a_in;
                        b_q     <= b_in;
                        arr_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state   <= S_FEED;
                    t       <= 3'd0;
                    arr_clr <= 1'b0;
                    left    <= left_nxt;
                    top     <= top_nxt;
                end
                S_FEED: begin
                    if (t == 3'd6) begin
                        state     <= S_DRAIN;
                        t         <= 3'd0;
                        drain_cnt <= 2'd2;
                        left      <= '0;
                        top       <= '0;
                    end else begin
                        t    <= t_nxt;
                        left <= left_nxt;
                        top  <= top_nxt;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    t       <= 3'd0;
                    left    <= '0;
                    top     <= '0;
                    arr_clr <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder.
// A cycle-index model derives every output from the captured matrices. A
// compare process checks the DUT against that model on each falling edge.
// Directed transfers then pin specific sequences to hand-written literals.
// A small behavioural systolic array consumes left/top so the final products
// can be checked as well.
module tb_systolic_feeder;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [44:0]      a_in;
    logic [44:0]      b_in;
    logic [2:0][4:0]  left;
    logic [2:0][4:0]  top;
    logic             arr_clr;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_pass = 0;

    systolic_feeder dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .left    (left),
        .top     (top),
        .arr_clr (arr_clr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // kind 0: identity, 1: every element v, 2: element (r,c) = 3r+c+1
    function automatic logic [44:0] mk(input int kind, input int v);
        logic [44:0] m;
        m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                case (kind)
                    0:       m[(3*r+c)*5 +: 5] = (r == c) ? 5'd1 : 5'd0;
                    1:       m[(3*r+c)*5 +: 5] = 5'(v);
                    default: m[(3*r+c)*5 +: 5] = 5'(3*r + c + 1);
                endcase
            end
        return m;
    endfunction

    // Model: p = 0 idle, else the cycle index since start was accepted (1..12).
    int          p;
    logic [44:0] m_a;
    logic [44:0] m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= 0;
        end else if (p == 0) begin
            if (start) begin
                p   <= 1;
                m_a <= a_in;
                m_b <= b_in;
            end
        end else if (p == 12) begin
            p <= 0;
        end else begin
            p <= p + 1;
        end
    end

    always @(negedge clk) begin
        logic [2:0][4:0] el;
        logic [2:0][4:0] et;
        int tt;
        el = '0;
        et = '0;
        if (p >= 2 && p <= 8) begin
            tt = p - 2;
            for (int i = 0; i < 3; i++) begin
                if (tt - i >= 0 && tt - i <= 2) begin
                    el[i] = m_a[(3*i + tt - i)*5 +: 5];
                    et[i] = m_b[(3*(tt - i) + i)*5 +: 5];
                end
            end
        end
        chk("cyc_arr_clr", 64'(arr_clr), 64'(p == 1));
        chk("cyc_busy",    64'(busy),    64'(p >= 1 && p <= 11));
        chk("cyc_done",    64'(done),    64'(p == 12));
        chk("cyc_left",    64'(left),    64'(el));
        chk("cyc_top",     64'(top),     64'(et));
    end

    // Behavioural 3x3 output-stationary array fed by the DUT.
    logic [4:0] pa [3][3];
    logic [4:0] pb [3][3];
    int         acc [3][3];

    always @(posedge clk) begin : arr
        int av;
        int bv;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                if (j == 0) av = int'(left[i]); else av = int'(pa[i][j-1]);
                if (i == 0) bv = int'(top[j]);  else bv = int'(pb[i-1][j]);
                pa[i][j]  <= 5'(av);
                pb[i][j]  <= 5'(bv);
                acc[i][j] <= arr_clr ? 0 : acc[i][j] + av * bv;
            end
    end

    logic [2:0][4:0] rec_left [16];
    logic [2:0][4:0] rec_top  [16];
    logic [15:0]     rec_busy;
    logic [15:0]     rec_done;
    logic [15:0]     rec_clr;
    int              snap [3][3];

    task automatic sample(input int k);
        rec_left[k] = left;
        rec_top[k]  = top;
        rec_busy[k] = busy;
        rec_done[k] = done;
        rec_clr[k]  = arr_clr;
        if (k == 12)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) snap[i][j] = acc[i][j];
    endtask

    // Called at a falling edge while idle; that cycle becomes index 0.
    task automatic run(input int nper, input logic hold, input int chg_p);
        rec_busy = '0;
        rec_done = '0;
        rec_clr  = '0;
        start = 1'b1;
        sample(0);
        for (int k = 1; k < nper; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (k == chg_p) begin
                a_in = ~a_in;
                b_in = ~b_in;
            end
            sample(k);
        end
        start = 1'b0;
    endtask

    function automatic logic [34:0] seq_l(input int i);
        return {rec_left[2][i], rec_left[3][i], rec_left[4][i], rec_left[5][i],
                rec_left[6][i], rec_left[7][i], rec_left[8][i]};
    endfunction

    function automatic logic [34:0] seq_t(input int j);
        return {rec_top[2][j], rec_top[3][j], rec_top[4][j], rec_top[5][j],
                rec_top[6][j], rec_top[7][j], rec_top[8][j]};
    endfunction

    initial begin
        int dcnt;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_left",  64'(left),    64'd0);
        chk("rst_top",   64'(top),     64'd0);
        chk("rst_flags", 64'({arr_clr, busy, done}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // A = identity, B = all ones
        a_in = mk(0, 0);
        b_in = mk(1, 1);
        run(14, 1'b0, -1);
        chk("id_left0", 64'(seq_l(0)), 64'({5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));
        chk("id_left2", 64'(seq_l(2)), 64'({5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0}));
        chk("id_top0",  64'(seq_t(0)), 64'({5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0}));
        chk("id_top1",  64'(seq_t(1)), 64'({5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0}));
        chk("id_top2",  64'(seq_t(2)), 64'({5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0}));

        // A = B = all 31
        a_in = mk(1, 31);
        b_in = mk(1, 31);
        run(14, 1'b0, -1);
        chk("max_left1", 64'(seq_l(1)), 64'({5'd0, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0}));
        chk("max_top2",  64'(seq_t(2)), 64'({5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0}));
        chk("max_busy",  64'(rec_busy), 64'h0FFE);
        chk("max_done",  64'(rec_done), 64'h1000);
        chk("max_clr",   64'(rec_clr),  64'h0002);

        // start held high, operands flipped mid-FEED
        a_in = mk(2, 0);
        b_in = mk(1, 7);
        run(16, 1'b1, 4);
        chk("hold_clr",   64'(rec_clr),          64'h4002);
        chk("hold_done",  64'(rec_done),         64'h1000);
        chk("hold_l0_t1", 64'(rec_left[3][0]),   64'd2);
        chk("hold_l1_t3", 64'(rec_left[5][1]),   64'd6);
        chk("hold_t2_t3", 64'(rec_top[5][2]),    64'd7);
        repeat (14) @(negedge clk);

        // reset at FEED step 3 (cycle index 5)
        a_in = mk(1, 31);
        b_in = mk(1, 31);
        run(6, 1'b0, -1);
        chk("ab_pre_left", 64'(left), 64'({5'd31, 5'd31, 5'd0}));
        #2 rst = 1'b1;
        #1;
        chk("ab_left", 64'(left), 64'd0);
        chk("ab_top",  64'(top),  64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ab_no_done", 64'(dcnt), 64'd0);
        run(14, 1'b0, -1);
        chk("ab_restart_done", 64'(rec_done), 64'h1000);

        // A[i][k] = 3i+k+1, B = identity: array result equals A
        a_in = mk(2, 0);
        b_in = mk(0, 0);
        run(14, 1'b0, -1);
        chk("arr_c00", 64'(snap[0][0]), 64'd1);
        chk("arr_c01", 64'(snap[0][1]), 64'd2);
        chk("arr_c02", 64'(snap[0][2]), 64'd3);
        chk("arr_c10", 64'(snap[1][0]), 64'd4);
        chk("arr_c11", 64'(snap[1][1]), 64'd5);
        chk("arr_c12", 64'(snap[1][2]), 64'd6);
        chk("arr_c20", 64'(snap[2][0]), 64'd7);
        chk("arr_c21", 64'(snap[2][1]), 64'd8);
        chk("arr_c22", 64'(snap[2][2]), 64'd9);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
